chaos_telemetry_framer: RTL and testbench

CHAOS_TELEMETRY_FRAMER -- requirements
Module: chaos_telemetry_framer

---
 rtl/chaos_telemetry_framer_pkg.sv | 22 ++
 rtl/chaos_telemetry_framer_if.sv | 24 ++
 rtl/chaos_frame_checksum.sv | 23 ++
 rtl/chaos_telemetry_framer.sv | 166 ++++++++++++++++
 tb/tb_chaos_telemetry_framer.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/chaos_telemetry_framer_pkg.sv
// Shared types and constants for the telemetry framer.
// Holds the sync byte, FSM states and frame-length helper.
package chaos_telemetry_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT,
        NEXT
    } frame_state_t;

    // Total frame bytes: sync + mask + data + checksum.
    function automatic logic [7:0] frame_len(
        input logic [7:0] mask,
        input int         bytes_per
    );
        return 8'(3 + $countones(mask) * bytes_per);
    endfunction

endpackage

// File: rtl/chaos_telemetry_framer_if.sv
// Byte link between the framer and a UART transmitter.
// Framer side is master, UART side is slave.
interface chaos_telemetry_framer_if;

    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_active;
    logic       tx_done;

    modport master (
        output tx_start,
        output tx_data,
        input  tx_active,
        input  tx_done
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx_active,
        output tx_done
    );

endinterface

// File: rtl/chaos_frame_checksum.sv
// Running mod-256 sum of the bytes covered by the checksum.
// The framer emits the two's complement of value as the final byte.
module chaos_frame_checksum (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       add,
    input  logic [7:0] add_byte,
    output logic [7:0] value
);

    // Clear wins over add so a new frame always starts from zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value <= 8'h00;
        end else if (clear) begin
            value <= 8'h00;
        end else if (add) begin
            value <= value + add_byte;
        end
    end

endmodule

// File: rtl/chaos_telemetry_framer.sv
// Captures decimated channel samples and streams them as framed
// bytes (sync, mask, data LSB first, checksum) to a UART.
module chaos_telemetry_framer
    import chaos_telemetry_pkg::*;
#(
    parameter int NUM_CH   = 3,
    parameter int SAMPLE_W = 32,
    parameter int DECIM    = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       sample_valid,
    input  logic [NUM_CH*SAMPLE_W-1:0] sample_data,
    input  logic [NUM_CH-1:0]          ch_mask,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    input  logic                       tx_active,
    input  logic                       tx_done,
    output logic                       frame_busy,
    output logic                       overrun,
    output logic [15:0]                frame_count
);

    localparam int BYTES = SAMPLE_W / 8;
    localparam int BUF_W = NUM_CH * SAMPLE_W;
    localparam logic [15:0] DEC_LAST = 16'(DECIM - 1);

    frame_state_t state;

    logic [15:0]      dec_cnt;
    logic             capture;
    logic [7:0]       mask8;
    logic [BUF_W-1:0] packed_data;
    logic [BUF_W-1:0] buf_q;
    logic [7:0]       mask_q;
    logic [7:0]       len_q;
    logic [7:0]       idx;
    logic [7:0]       nidx;
    logic [7:0]       next_byte;
    logic             next_is_data;
    logic             cs_clear;
    logic             cs_add;
    logic [7:0]       cs_value;
    int               off;

    assign capture = enable && sample_valid && (dec_cnt == DEC_LAST);
    assign nidx = idx + 8'd1;

    // Zero-extend the live channel mask to a full byte.
    always_comb begin
        mask8 = 8'h00;
        mask8[NUM_CH-1:0] = ch_mask;
    end

    // Compact the enabled channels into ascending order, LSB first.
    always_comb begin
        packed_data = '0;
        off = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_mask[k]) begin
                packed_data = packed_data |
                    (BUF_W'(sample_data[k*SAMPLE_W +: SAMPLE_W])
                     << (off * SAMPLE_W));
                off = off + 1;
            end
        end
    end

    // Pick the byte that follows the current one in the frame.
    always_comb begin
        next_is_data = (nidx >= 8'd2) && (nidx < len_q - 8'd1);
        if (nidx == 8'd1) begin
            next_byte = mask_q;
        end else if (nidx == len_q - 8'd1) begin
            next_byte = ~cs_value + 8'd1;
        end else begin
            next_byte = buf_q[7:0];
        end
    end

    assign cs_clear = capture && (state == IDLE);
    assign cs_add   = (state == NEXT) && (nidx < len_q - 8'd1);

    chaos_frame_checksum u_checksum (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (cs_clear),
        .add      (cs_add),
        .add_byte (next_byte),
        .value    (cs_value)
    );

    // Decimation counter; only strobes seen while enabled count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dec_cnt <= 16'd0;
        end else if (enable && sample_valid) begin
            dec_cnt <= capture ? 16'd0 : dec_cnt + 16'd1;
        end
    end

    // Frame sequencer with registered UART-side outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            frame_busy  <= 1'b0;
            overrun     <= 1'b0;
            frame_count <= 16'd0;
            buf_q       <= '0;
            mask_q      <= 8'h00;
            len_q       <= 8'd0;
            idx         <= 8'd0;
        end else begin
            overrun <= capture && (state != IDLE);
            unique case (state)
                IDLE: begin
                    if (capture) begin
                        buf_q      <= packed_data;
                        mask_q     <= mask8;
                        len_q      <= frame_len(mask8, BYTES);
                        idx        <= 8'd0;
                        tx_data    <= SYNC_BYTE;
                        tx_start   <= ~tx_active;
                        frame_busy <= 1'b1;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (tx_start) begin
                        tx_start <= 1'b0;
                        state    <= WAIT;
                    end else if (!tx_active) begin
                        tx_start <= 1'b1;
                    end
                end
                WAIT: begin
                    if (tx_done) begin
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    if (nidx < len_q) begin
                        idx      <= nidx;
                        tx_data  <= next_byte;
                        tx_start <= ~tx_active;
                        state    <= SEND;
                        if (next_is_data) begin
                            buf_q <= buf_q >> 8;
                        end
                    end else begin
                        frame_busy  <= 1'b0;
                        frame_count <= frame_count + 16'd1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chaos_telemetry_framer.sv
// Directed bench for the telemetry framer: frame table plus
// sequences for decimation, overrun, enable, busy UART and reset.
module tb_chaos_telemetry_framer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        sample_valid;
    logic [95:0] sample_data;
    logic [2:0]  ch_mask;
    logic        frame_busy;
    logic        overrun;
    logic [15:0] frame_count;

    logic        t4_start;
    logic [7:0]  t4_data;
    logic        t4_active;
    logic        t4_done;
    logic        fb4;
    logic        ov4;
    logic [15:0] fc4;

    int cyc = 0;
    int n_run = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Cycle counter for latency bookkeeping.
    always @(posedge clk) cyc <= cyc + 1;

    chaos_telemetry_framer_if u_if ();

    chaos_telemetry_framer #(
        .NUM_CH(3), .SAMPLE_W(32), .DECIM(1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .ch_mask      (ch_mask),
        .tx_start     (u_if.tx_start),
        .tx_data      (u_if.tx_data),
        .tx_active    (u_if.tx_active),
        .tx_done      (u_if.tx_done),
        .frame_busy   (frame_busy),
        .overrun      (overrun),
        .frame_count  (frame_count)
    );

    chaos_telemetry_framer #(
        .NUM_CH(3), .SAMPLE_W(32), .DECIM(4)
    ) dut4 (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .ch_mask      (ch_mask),
        .tx_start     (t4_start),
        .tx_data      (t4_data),
        .tx_active    (t4_active),
        .tx_done      (t4_done),
        .frame_busy   (fb4),
        .overrun      (ov4),
        .frame_count  (fc4)
    );

    typedef struct {
        logic [2:0]  mask;
        logic [95:0] data;
        int          n;
        logic [7:0]  b [16];
    } vec_t;

    vec_t vec [5];

    logic [7:0] bq [$];
    int         sq [$];
    int         s4q [$];
    logic [7:0] last_data;
    bit         inject_done = 1'b0;

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // UART model for dut: tx_done four cycles after each tx_start.
    initial begin : uart_main
        int  rcnt;
        bit  prev_start;
        rcnt = 0;
        prev_start = 1'b0;
        u_if.tx_done = 1'b0;
        forever begin
            @(negedge clk);
            u_if.tx_done = inject_done;
            if (u_if.tx_start === 1'b1) begin
                check("tx_start_one_cycle", 64'(prev_start), 64'd0);
                bq.push_back(u_if.tx_data);
                sq.push_back(cyc);
                last_data = u_if.tx_data;
                rcnt = 4;
            end else if (rcnt > 0) begin
                rcnt--;
                if (rcnt == 0) begin
                    u_if.tx_done = 1'b1;
                    if (frame_busy === 1'b1)
                        check("tx_data_stable", 64'(u_if.tx_data),
                              64'(last_data));
                end
            end
            prev_start = (u_if.tx_start === 1'b1);
        end
    end

    // UART model for the decimating instance.
    initial begin : uart_dec
        int rcnt;
        rcnt = 0;
        t4_done = 1'b0;
        forever begin
            @(negedge clk);
            t4_done = 1'b0;
            if (t4_start === 1'b1) begin
                if (t4_data == 8'hA5) s4q.push_back(cyc);
                rcnt = 4;
            end else if (rcnt > 0) begin
                rcnt--;
                if (rcnt == 0) t4_done = 1'b1;
            end
        end
    end

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (frame_busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle_timeout"}, 64'(n < 3000), 64'd1);
    endtask

    task automatic compare_frame(input int i, input string name);
        check({name, "_len"}, 64'(bq.size()), 64'(vec[i].n));
        for (int j = 0; j < vec[i].n; j++) begin
            if (j < bq.size())
                check($sformatf("%s_byte%0d", name, j),
                      64'(bq[j]), 64'(vec[i].b[j]));
        end
    endtask

    task automatic strobe(input int i, output int scyc);
        @(negedge clk);
        ch_mask = vec[i].mask;
        sample_data = vec[i].data;
        sample_valid = 1'b1;
        scyc = cyc;
        @(negedge clk);
        sample_valid = 1'b0;
        sample_data = ~sample_data;
        ch_mask = ~ch_mask;
    endtask

    task automatic run_vec(input int i);
        int          scyc;
        logic [15:0] fc0;
        string       nm;
        nm = $sformatf("vec%0d", i);
        bq.delete();
        sq.delete();
        fc0 = frame_count;
        strobe(i, scyc);
        check({nm, "_busy"}, 64'(frame_busy), 64'd1);
        wait_idle(nm);
        compare_frame(i, nm);
        if (sq.size() > 0)
            check({nm, "_latency"}, 64'(sq[0]), 64'(scyc + 1));
        check({nm, "_count"}, 64'(frame_count), 64'(fc0 + 16'd1));
    endtask

    initial begin : main
        int          scyc;
        int          s [8];
        int          n;
        logic [15:0] fc0;

        vec[0].mask = 3'b001;
        vec[0].data = {32'h0, 32'h0, 32'h12345678};
        vec[0].n = 7;
        vec[0].b = '{8'hA5, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEB,
                     0, 0, 0, 0, 0, 0, 0, 0, 0};
        vec[1].mask = 3'b111;
        vec[1].data = {32'h80000000, 32'hFFFFFFFF, 32'h00000001};
        vec[1].n = 15;
        vec[1].b = '{8'hA5, 8'h07, 8'h01, 8'h00, 8'h00, 8'h00,
                     8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00,
                     8'h00, 8'h80, 8'h7C, 0};
        vec[2].mask = 3'b000;
        vec[2].data = {32'h11111111, 32'h22222222, 32'h33333333};
        vec[2].n = 3;
        vec[2].b = '{8'hA5, 8'h00, 8'h00,
                     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vec[3].mask = 3'b010;
        vec[3].data = {32'h5555AAAA, 32'hDEADBEEF, 32'h33333333};
        vec[3].n = 7;
        vec[3].b = '{8'hA5, 8'h02, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hC6,
                     0, 0, 0, 0, 0, 0, 0, 0, 0};
        vec[4].mask = 3'b101;
        vec[4].data = {32'h0A0B0C0D, 32'hFFFF0000, 32'h01020304};
        vec[4].n = 11;
        vec[4].b = '{8'hA5, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01,
                     8'h0D, 8'h0C, 8'h0B, 8'h0A, 8'hC3,
                     0, 0, 0, 0, 0};

        rst_n = 1'b0;
        enable = 1'b1;
        sample_valid = 1'b0;
        sample_data = '0;
        ch_mask = 3'b000;
        u_if.tx_active = 1'b0;
        t4_active = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_tx_start", 64'(u_if.tx_start), 64'd0);
        check("rst_tx_data", 64'(u_if.tx_data), 64'h00);
        check("rst_busy", 64'(frame_busy), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_count", 64'(frame_count), 64'd0);
        check("rst_count4", 64'(fc4), 64'd0);
        rst_n = 1'b1;

        // Decimation: 8 strobes into DECIM=4 gives frames on 4 and 8.
        for (int i = 0; i < 8; i++) begin
            strobe(2, s[i]);
            repeat (28) @(negedge clk);
        end
        check("dec_frames", 64'(s4q.size()), 64'd2);
        if (s4q.size() >= 2) begin
            check("dec_first", 64'(s4q[0]), 64'(s[3] + 1));
            check("dec_second", 64'(s4q[1]), 64'(s[7] + 1));
        end
        check("dec_count4", 64'(fc4), 64'd2);
        check("dec_count1", 64'(frame_count), 64'd8);

        for (int i = 0; i < 5; i++) run_vec(i);

        // Capture during a frame is dropped with a one-cycle overrun.
        bq.delete();
        fc0 = frame_count;
        strobe(0, scyc);
        repeat (8) @(negedge clk);
        ch_mask = 3'b111;
        sample_data = {32'hCAFEF00D, 32'h0BADBEEF, 32'h77777777};
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        check("ovr_pulse", 64'(overrun), 64'd1);
        @(negedge clk);
        check("ovr_clear", 64'(overrun), 64'd0);
        wait_idle("ovr");
        compare_frame(0, "ovr");
        check("ovr_count", 64'(frame_count), 64'(fc0 + 16'd1));

        // Dropping enable mid-frame finishes the frame, no new ones.
        bq.delete();
        fc0 = frame_count;
        strobe(3, scyc);
        enable = 1'b0;
        repeat (5) @(negedge clk);
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        check("en_no_overrun", 64'(overrun), 64'd0);
        wait_idle("en");
        compare_frame(3, "en");
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("en_no_capture", 64'(frame_busy), 64'd0);
        check("en_count", 64'(frame_count), 64'(fc0 + 16'd1));
        enable = 1'b1;

        // Busy UART holds off tx_start.
        bq.delete();
        u_if.tx_active = 1'b1;
        strobe(1, scyc);
        repeat (9) @(negedge clk);
        check("act_held", 64'(bq.size()), 64'd0);
        check("act_busy", 64'(frame_busy), 64'd1);
        u_if.tx_active = 1'b0;
        repeat (3) @(negedge clk);
        check("act_release", 64'(bq.size()), 64'd1);
        wait_idle("act");
        compare_frame(1, "act");

        // Stray tx_done while idle does nothing.
        n = bq.size();
        inject_done = 1'b1;
        @(negedge clk);
        inject_done = 1'b0;
        repeat (3) @(negedge clk);
        check("stray_busy", 64'(frame_busy), 64'd0);
        check("stray_start", 64'(bq.size()), 64'(n));

        // Reset during the third byte aborts the frame.
        bq.delete();
        strobe(0, scyc);
        n = 0;
        while (bq.size() < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rst3_reached", 64'(n < 200), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst3_start", 64'(u_if.tx_start), 64'd0);
        check("rst3_busy", 64'(frame_busy), 64'd0);
        check("rst3_count", 64'(frame_count), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst3_after", 64'(u_if.tx_start), 64'd0);
        repeat (10) @(negedge clk);
        run_vec(0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
